// File: rtl/lcd_seq_ctrl.sv
// lcd_seq_ctrl: waits out LCD power-up, runs the HD44780 init list, then feeds chars/clears to the byte writer.
// Optional: define LCD_AUTOWRAP_EN to issue 0xC0 / 0x80 address commands when the cursor reaches 16 / wraps from 31.
module lcd_seq_ctrl #(
    parameter int POWERUP_DELAY = 750000,
    parameter int CMD_DELAY     = 2000,
    parameter int CLEAR_DELAY   = 82000
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [7:0] iChar,
    input  logic       iCharValid,
    output logic       oCharReady,
    input  logic       iClear,
    output logic       oInitDone,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oStart,
    input  logic       iDone
);
    typedef enum logic [2:0] {PWR_WAIT, ISSUE, WAIT_DONE, DELAY, IDLE} state_t;
    typedef enum logic [1:0] {SRC_INIT, SRC_USER, SRC_WRAP} src_t;

    localparam logic [19:0] PWR_LAST = 20'(POWERUP_DELAY - 1);
    localparam logic [19:0] CMD_LAST = 20'(CMD_DELAY - 1);
    localparam logic [19:0] CLR_LAST = 20'(CLEAR_DELAY - 1);

    state_t      state_q;
    src_t        src_q;
    logic [19:0] cnt_q;
    logic [4:0]  cursor_q;
    logic [4:0]  cursor_d;
    logic [2:0]  init_idx_q;
    logic [7:0]  data_q;
    logic        rs_q;
    logic        start_q;
    logic        init_done_q;
    logic        done_q;
    logic [19:0] delay_last;
    logic        done_rise;

    function automatic logic [7:0] init_cmd(input logic [2:0] idx);
        case (idx)
            3'd0:    return 8'h38;
            3'd1:    return 8'h0C;
            3'd2:    return 8'h01;
            3'd3:    return 8'h06;
            default: return 8'h80;
        endcase
    endfunction

    assign cursor_d   = cursor_q + 5'd1;
    // Only the clear command needs the long settle time; a data byte of 0x01 is an ordinary write.
    assign delay_last = (data_q == 8'h01 && !rs_q) ? CLR_LAST : CMD_LAST;
    assign done_rise  = iDone && !done_q;

    assign oCharReady = (state_q == IDLE) && !iClear;
    assign oInitDone  = init_done_q;
    assign oDATA      = data_q;
    assign oRS        = rs_q;
    assign oStart     = start_q;

    // NOTE: all state updates use <= so every branch sees the pre-edge values of the other registers.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q     <= PWR_WAIT;
            src_q       <= SRC_INIT;
            cnt_q       <= '0;
            cursor_q    <= '0;
            init_idx_q  <= '0;
            data_q      <= '0;
            rs_q        <= 1'b0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q  <= iDone;
            start_q <= 1'b0;
            case (state_q)
                PWR_WAIT: begin
                    if (cnt_q == PWR_LAST) begin
                        cnt_q      <= '0;
                        init_idx_q <= 3'd0;
                        data_q     <= init_cmd(3'd0);
                        rs_q       <= 1'b0;
                        src_q      <= SRC_INIT;
                        state_q    <= ISSUE;
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                ISSUE: begin
                    start_q <= 1'b1;
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (done_rise) begin
                        cnt_q   <= '0;
                        state_q <= DELAY;
                    end
                end
                DELAY: begin
                    if (cnt_q == delay_last) begin
                        cnt_q <= '0;
                        case (src_q)
                            SRC_INIT: begin
                                if (init_idx_q == 3'd4) begin
                                    init_done_q <= 1'b1;
                                    state_q     <= IDLE;
                                end else begin
                                    init_idx_q <= init_idx_q + 3'd1;
                                    data_q     <= init_cmd(init_idx_q + 3'd1);
                                    state_q    <= ISSUE;
                                end
                            end
                            SRC_USER: begin
                                state_q <= IDLE;
                                if (rs_q) begin
                                    cursor_q <= cursor_d;
`ifdef LCD_AUTOWRAP_EN
                                    if (cursor_d == 5'd16 || cursor_d == 5'd0) begin
                                        data_q  <= (cursor_d == 5'd16) ? 8'hC0 : 8'h80;
                                        rs_q    <= 1'b0;
                                        src_q   <= SRC_WRAP;
                                        state_q <= ISSUE;
                                    end
`endif
                                end
                            end
                            default: state_q <= IDLE;
                        endcase
                    end else begin
                        cnt_q <= cnt_q + 20'd1;
                    end
                end
                IDLE: begin
                    if (iClear) begin
                        data_q   <= 8'h01;
                        rs_q     <= 1'b0;
                        cursor_q <= '0;
                        src_q    <= SRC_USER;
                        state_q  <= ISSUE;
                    end else if (iCharValid) begin
                        data_q  <= iChar;
                        rs_q    <= 1'b1;
                        src_q   <= SRC_USER;
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= PWR_WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Self-checking bench for lcd_seq_ctrl: a timing model predicts every oStart (cycle, byte, RS) and oCharReady.
module tb_lcd_seq_ctrl;
    localparam int PD    = 10;
    localparam int CD    = 4;
    localparam int KD    = 8;
    localparam int WL    = 3;
    localparam int NEVER = 32'h3fff_ffff;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b1;
    logic [7:0] iChar = 8'h00;
    logic       iCharValid = 1'b0;
    logic       iClear = 1'b0;
    logic       iDone = 1'b1;
    logic       oCharReady;
    logic       oInitDone;
    logic [7:0] oDATA;
    logic       oRS;
    logic       oStart;

    lcd_seq_ctrl #(
        .POWERUP_DELAY(PD),
        .CMD_DELAY    (CD),
        .CLEAR_DELAY  (KD)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iChar     (iChar),
        .iCharValid(iCharValid),
        .oCharReady(oCharReady),
        .iClear    (iClear),
        .oInitDone (oInitDone),
        .oDATA     (oDATA),
        .oRS       (oRS),
        .oStart    (oStart),
        .iDone     (iDone)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
        logic       rs;
    } ev_t;

    typedef struct {
        bit         clear;
        bit         valid;
        logic [7:0] ch;
        logic [7:0] exp_data;
        bit         exp_rs;
        int         exp_cursor;
    } vec_t;

    ev_t  exp_q[$];
    ev_t  act_q[$];
    vec_t vecs[5];
    int   n_cmp = 0;
    int   n_err = 0;
    int   t0 = 0;
    int   rel = 0;
    int   idle_edge = NEVER;
    int   cursor_m = 0;
    int   wr_cnt = 0;
    bit   id_seen = 1'b0;
    int   id_edge = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int c, input logic [7:0] d, input logic r);
        exp_q.push_back('{c, d, r});
    endtask

    // Reference: an accepted request at edge a starts at a+1; the sequencer is idle again after
    // writer latency + edge detect + post-command delay, plus one more command when the line wraps.
    task automatic model_accept(input bit clear, input logic [7:0] ch);
        int a;
        a = rel + 1;
        if (clear) begin
            push_exp(a + 1, 8'h01, 1'b0);
            cursor_m  = 0;
            idle_edge = a + 1 + WL + 1 + KD;
        end else begin
            push_exp(a + 1, ch, 1'b1);
            idle_edge = a + 1 + WL + 1 + CD;
            cursor_m  = (cursor_m + 1) % 32;
`ifdef LCD_AUTOWRAP_EN
            if (cursor_m == 16 || cursor_m == 0) begin
                push_exp(idle_edge + 1, (cursor_m == 16) ? 8'hC0 : 8'h80, 1'b0);
                idle_edge = idle_edge + 1 + WL + 1 + CD;
            end
`endif
        end
    endtask

    // One clock: writer model, start monitor, drive requests, then check oCharReady.
    task automatic tick(input bit clear, input bit valid, input logic [7:0] ch);
        @(negedge iCLK);
        rel = cyc - t0;
        if (oStart) begin
            wr_cnt = WL;
            iDone  = 1'b0;
        end else if (wr_cnt > 0) begin
            wr_cnt--;
            if (wr_cnt == 0) iDone = 1'b1;
        end
        if (oStart) act_q.push_back('{rel, oDATA, oRS});
        if (oInitDone && !id_seen) begin
            id_seen = 1'b1;
            id_edge = rel;
        end
        iClear     = clear;
        iCharValid = valid;
        iChar      = ch;
        #1;
        check("char_ready", 32'(oCharReady), 32'((rel >= idle_edge) && !clear));
        if (rel >= idle_edge && (clear || valid)) model_accept(clear, ch);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && rel < idle_edge; k++) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic compare_events(input string tag);
        check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_cycle"}, 32'(act_q[i].cyc), 32'(exp_q[i].cyc));
            check({tag, "_data"}, 32'(act_q[i].data), 32'(exp_q[i].data));
            check({tag, "_rs"}, 32'(act_q[i].rs), 32'(exp_q[i].rs));
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic run_init(input string tag);
        logic [7:0] cmds[5];
        int         e;
        int         done_edge;
        cmds = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
        @(negedge iCLK);
        iRST_N   = 1'b1;
        t0       = cyc;
        rel      = 0;
        id_seen  = 1'b0;
        id_edge  = -1;
        cursor_m = 0;
        e = PD + 1;
        for (int i = 0; i < 5; i++) begin
            push_exp(e, cmds[i], 1'b0);
            if (i < 4) e = e + WL + 1 + ((cmds[i] == 8'h01) ? KD : CD) + 1;
        end
        done_edge = e + WL + 1 + CD;
        idle_edge = done_edge;
        for (int k = 0; k < done_edge + 2; k++) tick(1'b0, 1'b0, 8'h00);
        check({tag, "_initdone_seen"}, 32'(id_seen), 32'd1);
        check({tag, "_initdone_cycle"}, 32'(id_edge), 32'(done_edge));
        compare_events(tag);
        check({tag, "_cursor"}, 32'(dut.cursor_q), 32'(cursor_m));
    endtask

    initial begin
        int n_cmd;
        int n_dat;
        bit clr;
        bit vld;

        vecs[0] = '{1'b0, 1'b1, 8'h41, 8'h41, 1'b1, 1};
        vecs[1] = '{1'b1, 1'b1, 8'h42, 8'h01, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 8'h55, 8'h55, 1'b1, 1};
        vecs[3] = '{1'b0, 1'b1, 8'h7A, 8'h7A, 1'b1, 2};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 8'h01, 1'b0, 0};

        #1 iRST_N = 1'b0;
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        check("rst_data", 32'(oDATA), 32'd0);
        check("rst_rs", 32'(oRS), 32'd0);
        check("rst_start", 32'(oStart), 32'd0);
        check("rst_initdone", 32'(oInitDone), 32'd0);
        check("rst_ready", 32'(oCharReady), 32'd0);

        run_init("init");

        foreach (vecs[i]) begin
            drain();
            tick(vecs[i].clear, vecs[i].valid, vecs[i].ch);
            tick(1'b0, 1'b0, 8'h00);
            drain();
            check("vec_starts", 32'(act_q.size()), 32'd1);
            if (act_q.size() > 0) begin
                check("vec_data", 32'(act_q[0].data), 32'(vecs[i].exp_data));
                check("vec_rs", 32'(act_q[0].rs), 32'(vecs[i].exp_rs));
            end
            check("vec_cursor", 32'(dut.cursor_q), 32'(vecs[i].exp_cursor));
            compare_events("vec");
        end

        // Char request pulsed while the previous char is in its post-write delay.
        drain();
        tick(1'b0, 1'b1, 8'h44);
        repeat (6) tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h45);
        tick(1'b0, 1'b0, 8'h00);
        drain();
        check("delay_pulse_starts", 32'(act_q.size()), 32'd1);
        compare_events("delay_pulse");

        // Thirty-two characters from a cleared display.
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        drain();
        compare_events("wrap_clear");
        for (int k = 0; k < 32; k++) begin
            drain();
            tick(1'b0, 1'b1, 8'h30 + 8'(k));
        end
        tick(1'b0, 1'b0, 8'h00);
        drain();
        n_cmd = 0;
        n_dat = 0;
        foreach (act_q[i]) begin
            if (act_q[i].rs) n_dat++;
            else n_cmd++;
        end
        check("wrap_data_bytes", 32'(n_dat), 32'd32);
`ifdef LCD_AUTOWRAP_EN
        check("wrap_cmd_bytes", 32'(n_cmd), 32'd2);
        if (act_q.size() == 34) begin
            check("wrap_line2_cmd", 32'(act_q[16].data), 32'hC0);
            check("wrap_home_cmd", 32'(act_q[33].data), 32'h80);
        end
`else
        check("wrap_cmd_bytes", 32'(n_cmd), 32'd0);
`endif
        check("wrap_cursor", 32'(dut.cursor_q), 32'd0);
        compare_events("wrap");

        for (int k = 0; k < 800; k++) begin
            clr = ($urandom_range(15) == 0);
            vld = ($urandom_range(2) == 0);
            tick(clr, vld, 8'($urandom_range(126, 32)));
        end
        tick(1'b0, 1'b0, 8'h00);
        drain();
        compare_events("random");
        check("random_cursor", 32'(dut.cursor_q), 32'(cursor_m));

        // Reset asserted while a char is in flight, in the cycle its start pulse is high.
        drain();
        tick(1'b0, 1'b1, 8'h52);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        compare_events("pre_reset");
        iRST_N    = 1'b0;
        idle_edge = NEVER;
        #1;
        check("abort_start", 32'(oStart), 32'd0);
        check("abort_data", 32'(oDATA), 32'd0);
        check("abort_rs", 32'(oRS), 32'd0);
        check("abort_initdone", 32'(oInitDone), 32'd0);
        check("abort_ready", 32'(oCharReady), 32'd0);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        run_init("reinit");

        drain();
        tick(1'b0, 1'b1, 8'h5A);
        tick(1'b0, 1'b0, 8'h00);
        drain();
        compare_events("post_reinit");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lcd_seq_ctrl.md
# lcd_seq_ctrl

Sequencer for the character LCD byte writer. After reset it waits out the LCD power-up time and issues the HD44780 init command list. It then accepts characters and clear requests from the system and feeds each byte to the writer with the required post-command delay. It sits between application logic and the writer, driving the writer's data/RS/start inputs and watching its done output.

## Interface

- `POWERUP_DELAY`, default 750000: cycles to wait after reset before the first command (15 ms at 50 MHz).
- `CMD_DELAY`, default 2000: cycles to wait after each non-clear byte completes (40 us).
- `CLEAR_DELAY`, default 82000: cycles to wait after the clear command 0x01 completes (1.64 ms).
- `iCLK` input 1: system clock; all logic on its rising edge.
- `iRST_N` input 1: asynchronous active-low reset.
- `iChar` input 8: character code to display.
- `iCharValid` input 1: character request.
- `oCharReady` output 1: controller can accept a character this cycle.
- `iClear` input 1: request a display clear (level, sampled only in IDLE).
- `oInitDone` output 1: init sequence finished; stays high until reset.
- `oDATA` output 8: byte to the writer.
- `oRS` output 1: register select to the writer (0 = command, 1 = data).
- `oStart` output 1: one-cycle start pulse to the writer.
- `iDone` input 1: writer done level; a transfer completes on its rising edge.

## Operation

- **Reset values:** all outputs are 0. State is PWR_WAIT, the delay counter is 0, the cursor is 0, and the init index is 0.
- **PWR_WAIT:** count to `POWERUP_DELAY`-1, then go to ISSUE with the init list.
- **Init list, in order:** 0x38, 0x0C, 0x01, 0x06, 0x80, all with RS=0.
- **ISSUE:**
  - Drive `oDATA`/`oRS` and pulse `oStart` for exactly one cycle.
  - Go to WAIT_DONE.
- **WAIT_DONE:**
  - Register `iDone` and wait for 0→1.
  - `oDATA`/`oRS` are held stable from the `oStart` cycle until this edge.
  - Go to DELAY.
- **DELAY:**
  - Count `CLEAR_DELAY` cycles if the byte was 0x01, else `CMD_DELAY`.
  - Then go to the next list entry, a pending follow-up byte, or IDLE.
  - On leaving the last init entry, set `oInitDone`=1.
- **IDLE:**
  - `oCharReady` = (state==IDLE) && !`iClear`; this output is combinational.
  - If `iClear`=1: issue 0x01 (RS=0) and set cursor to 0. Clear has priority; a char is never accepted in the same cycle as a clear.
  - Else if `iCharValid` && `oCharReady`: latch `iChar` and issue it with RS=1; cursor increments after completion.
- The cursor is a 5-bit column/line index 0..31 (0–15 = line 1, 16–31 = line 2).
- The delay counter is 20 bits wide and counts up to the target minus 1.
- Requests arriving outside IDLE are ignored; no queueing.
- Reset asserted mid-transfer aborts immediately and returns to PWR_WAIT. `oStart` drops to 0 asynchronously, and the full power-up wait and init list run again.

## Timing

- `oStart` is high one cycle after entering ISSUE and lasts exactly 1 cycle.
- The minimum gap between consecutive `oStart` pulses is writer latency + 1 (edge detect) + delay parameter + 1 (ISSUE).
- **Char latency:** handshake cycle → IDLE exit; `oStart` follows on the next cycle.
- `oCharReady` falls in the cycle after the accept. It stays low through WAIT_DONE/DELAY and any wrap command.
- The first init `oStart` is asserted `POWERUP_DELAY`+1 cycles after `iRST_N` deasserts.

## Configuration

- `LCD_AUTOWRAP_EN` defined:
  - After a char completes, if the cursor becomes 16, issue a follow-up 0xC0 (RS=0, `CMD_DELAY`) before returning to IDLE.
  - If it becomes 32, wrap the cursor to 0 and issue 0x80 instead.
- Not defined:
  - No follow-up commands are issued. The cursor register still counts and wraps 31→0 (unused).
  - Characters are written back-to-back with the LCD's own addressing.

## Test plan

Use `POWERUP_DELAY`=10, `CMD_DELAY`=4, `CLEAR_DELAY`=8, and a writer model that raises done 3 cycles after start.

- **Reset release:** first `oStart` with `oDATA`=0x38, RS=0 at cycle 11. Five commands follow (0x38, 0x0C, 0x01, 0x06, 0x80), and the gap after 0x01 is 4 cycles longer than the others. `oInitDone` rises after 0x80's delay.
- **Char 0x41 in IDLE:** one `oStart` with `oDATA`=0x41, RS=1. `oCharReady` is low until the delay ends, then high again.
- **Clear and char together** (`iClear`=1 with `iCharValid`=1, `iChar`=0x42): only 0x01 is issued and the char is not accepted. The cursor reads 0 afterwards.
- **Line wrap, `LCD_AUTOWRAP_EN`:** write 16 chars; 0xC0 is issued after the 16th. At the 32nd, 0x80 is issued and the cursor reads 0. Without the macro, 32 data bytes are issued with no commands between them.
- **Reset during WAIT_DONE of a char:** outputs go to 0 immediately and `oInitDone`=0. After release the init sequence restarts from 0x38.
- **`iCharValid` pulsed during DELAY:** ignored, with no extra `oStart`.
